// File: rtl/evm_disp_pkg.sv
// Shared FSM state type and display constants for the vote-count BCD display scheduler.
package evm_disp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        SETTLE  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    localparam int         BCD_DIGITS = 5;
    localparam int         BCD_W      = 20;
    localparam logic [4:0] AN_OFF     = 5'b11111;

endpackage

// File: rtl/seg_digit_scan.sv
// Free-running 5-digit multiplexed 7-segment scanner: slot divider, anode decode, digit mux.
// Optional leading-zero blanking when LZ_BLANK_EN is defined.
module seg_digit_scan
    import evm_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BCD_W-1:0]      value,
    output logic [BCD_DIGITS-1:0] an_n,
    output logic [3:0]            digit
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0]      div_cnt;
    logic                  div_wrap;
    logic [2:0]            slot;
    logic [2:0]            slot_next;
    logic [BCD_DIGITS-1:0] an_next;
    logic [3:0]            digit_next;

    assign div_wrap = (div_cnt == DIV_W'(SCAN_DIV - 1));

    // value is the figure the display holds after this edge, so anode and digit stay aligned with it
    always_comb begin
        slot_next = slot;
        if (div_wrap) begin
            slot_next = (slot == 3'(BCD_DIGITS - 1)) ? 3'd0 : slot + 3'd1;
        end
        an_next    = ~(BCD_DIGITS'(1) << slot_next);
        digit_next = 4'(value >> {slot_next, 2'b00});
`ifdef LZ_BLANK_EN
        if ((slot_next != 3'd0) && ((value >> {slot_next, 2'b00}) == '0)) begin
            an_next = AN_OFF;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
            slot    <= '0;
            an_n    <= 5'b11110;
            digit   <= '0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
            slot    <= slot_next;
            an_n    <= an_next;
            digit   <= digit_next;
        end
    end

endmodule

// File: rtl/bcd_display_scheduler.sv
// Time-shares one external binary-to-BCD converter across NUM_CAND vote counters and shows the result
// on a 5-digit multiplexed display. Leading-zero blanking is enabled by defining LZ_BLANK_EN.
//
// state   | meaning
// IDLE    | waiting for a pending conversion request
// LOAD    | snapshot the selected count onto conv_bin, clear pending
// SETTLE  | hold conv_bin for SETTLE_CYCLES while the converter settles
// CAPTURE | latch conv_bcd into bcd_value; chain straight into LOAD if another request is pending
module bcd_display_scheduler
    import evm_disp_pkg::*;
#(
    parameter int NUM_CAND      = 4,
    parameter int CNT_W         = 14,
    parameter int SEL_W         = 2,
    parameter int DWELL_CYCLES  = 100_000_000,
    parameter int SETTLE_CYCLES = 2,
    parameter int SCAN_DIV      = 50_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CAND*CNT_W-1:0] cnt_bus,
    input  logic                      auto_en,
    input  logic [SEL_W-1:0]          man_sel,
    output logic [CNT_W-1:0]          conv_bin,
    input  logic [BCD_W-1:0]          conv_bcd,
    output logic [BCD_W-1:0]          bcd_value,
    output logic                      bcd_valid,
    output logic [SEL_W-1:0]          cand_id,
    output logic                      busy,
    output logic [BCD_DIGITS-1:0]     an_n,
    output logic [3:0]                digit
);

    localparam int DWELL_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    state_t              state;
    state_t              state_next;
    logic                pending;
    logic [DWELL_W-1:0]  dwell_cnt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                tick;
    logic                man_req;
    logic                req;
    logic                sel_open;
    logic [SEL_W-1:0]    cand_next;
    logic [BCD_W-1:0]    bcd_next;

    assign tick     = (dwell_cnt == DWELL_W'(DWELL_CYCLES - 1));
    assign man_req  = !auto_en && (32'(man_sel) < NUM_CAND) && (man_sel != cand_id);
    assign req      = tick || man_req;
    // Manual selection is only taken between conversions so cand_id never moves under a running LOAD/SETTLE
    assign sel_open = (state == IDLE) || (state == CAPTURE);
    assign bcd_next = (state == CAPTURE) ? conv_bcd : bcd_value;

    always_comb begin
        cand_next = cand_id;
        if (tick && auto_en) begin
            cand_next = (cand_id == SEL_W'(NUM_CAND - 1)) ? '0 : cand_id + SEL_W'(1);
        end else if (man_req && sel_open) begin
            cand_next = man_sel;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pending || req) state_next = LOAD;
            LOAD:    state_next = SETTLE;
            SETTLE:  if (settle_cnt == '0) state_next = CAPTURE;
            CAPTURE: state_next = (pending || req) ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pending    <= 1'b1;
            dwell_cnt  <= '0;
            settle_cnt <= '0;
            cand_id    <= '0;
            conv_bin   <= '0;
            bcd_value  <= '0;
            bcd_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state     <= state_next;
            busy      <= (state_next != IDLE);
            cand_id   <= cand_next;
            dwell_cnt <= tick ? '0 : dwell_cnt + DWELL_W'(1);
            bcd_valid <= (state == CAPTURE);
            if (state == CAPTURE) begin
                bcd_value <= conv_bcd;
            end
            // A request arriving in LOAD itself must survive the clear
            if (state == LOAD) begin
                conv_bin   <= CNT_W'(cnt_bus >> (32'(cand_id) * CNT_W));
                pending    <= req;
                settle_cnt <= SETTLE_W'(SETTLE_CYCLES - 1);
            end else begin
                pending <= pending || req;
                if (settle_cnt != '0) begin
                    settle_cnt <= settle_cnt - SETTLE_W'(1);
                end
            end
        end
    end

    seg_digit_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk   (clk),
        .rst_n (rst_n),
        .value (bcd_next),
        .an_n  (an_n),
        .digit (digit)
    );

endmodule
